// File: rtl/fft_twiddle_seq_gen_pkg.sv
// Shared definitions for the twiddle-factor generator: FSM states, default
// table sizing and the elaboration-time cosine table function.
package fft_twid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } twid_state_e;

  // Default FFT size used by the top module parameters.
  localparam int N_LOG2_DEF = 5;
  localparam int QLEN       = (2 ** N_LOG2_DEF) / 4 + 1;
  localparam int STRIDE_W   = $clog2(N_LOG2_DEF);

  // round(2^frac_w * cos(2*pi*r/N)), half away from zero. The cosine is a
  // Taylor series so the table can be evaluated as a constant function.
  function automatic int twid_cos_q(input int n_log2, input int frac_w, input int r);
    real x;
    real term;
    real sum;
    real scaled;
    int  res;
    x    = 3.14159265358979323846 * real'(r) * 2.0 / real'(2 ** n_log2);
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i <= 24; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    scaled = sum * real'(2 ** frac_w);
    if (scaled >= 0.0) begin
      res = $rtoi(scaled + 0.5);
    end else begin
      res = -$rtoi(0.5 - scaled);
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_twiddle_seq_gen_rom.sv
// Synchronous-read twiddle ROM with two read ports.
// Default build: quarter-wave cosine table, ports read C[addr_a] and C[addr_b].
// With FFT_TWID_FULL_ROM_EN defined: full N-entry table, data_a = re[addr_a],
// data_b = im[addr_b] (forward direction).
module fft_twid_quarter_rom
  import fft_twid_pkg::*;
#(
  parameter int N_LOG2 = 5,
  parameter int DATA_W = 16,
  parameter int FRAC_W = DATA_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_LOG2-1:0] addr_a,
  input  logic [N_LOG2-1:0] addr_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b
);

  localparam int NQ = (2 ** N_LOG2) / 4;

`ifdef FFT_TWID_FULL_ROM_EN
  localparam int DEPTH = 2 ** N_LOG2;

  // Full complex table, folded once at elaboration time.
  function automatic logic [DEPTH*DATA_W-1:0] build_tab(input bit want_im);
    logic [DEPTH*DATA_W-1:0] t;
    int q;
    int r;
    int c;
    int cp;
    int re;
    int im;
    t = {(DEPTH*DATA_W){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      q  = k / NQ;
      r  = k % NQ;
      c  = twid_cos_q(N_LOG2, FRAC_W, r);
      cp = twid_cos_q(N_LOG2, FRAC_W, NQ - r);
      case (q)
        32'sd0:  begin re = c;   im = -cp; end
        32'sd1:  begin re = -cp; im = -c;  end
        32'sd2:  begin re = -c;  im = cp;  end
        32'sd3:  begin re = cp;  im = c;   end
        default: begin re = 0;   im = 0;   end
      endcase
      t[k*DATA_W +: DATA_W] = want_im ? DATA_W'(im) : DATA_W'(re);
    end
    return t;
  endfunction

  localparam logic [DEPTH*DATA_W-1:0] TAB_A = build_tab(1'b0);
  localparam logic [DEPTH*DATA_W-1:0] TAB_B = build_tab(1'b1);
`else
  // Quarter-wave cosine table C[0..N/4].
  function automatic logic [(NQ+1)*DATA_W-1:0] build_tab();
    logic [(NQ+1)*DATA_W-1:0] t;
    t = {((NQ+1)*DATA_W){1'b0}};
    for (int r = 0; r <= NQ; r++) begin
      t[r*DATA_W +: DATA_W] = DATA_W'(twid_cos_q(N_LOG2, FRAC_W, r));
    end
    return t;
  endfunction

  localparam logic [(NQ+1)*DATA_W-1:0] TAB_A = build_tab();
  localparam logic [(NQ+1)*DATA_W-1:0] TAB_B = TAB_A;
`endif

  // Registered read; holds its data while the downstream pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_a <= {DATA_W{1'b0}};
      data_b <= {DATA_W{1'b0}};
    end else if (en) begin
      data_a <= TAB_A[int'(addr_a)*DATA_W +: DATA_W];
      data_b <= TAB_B[int'(addr_b)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/fft_twiddle_seq_gen.sv
// Twiddle-factor sequencer: streams W_N^k for all k of one radix-2 stage over
// a valid/ready handshake through a 3-stage stallable pipeline
// (P1 fold control, P2 ROM read, P3 sign/swap).
// Build option FFT_TWID_FULL_ROM_EN selects a full complex ROM instead of the
// quarter-wave table plus fold; outputs and timing are identical.
module fft_twiddle_seq_gen
  import fft_twid_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DATA_W = 16,
  parameter int FRAC_W = DATA_W - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(N_LOG2)-1:0]  stage,
  input  logic                       inverse,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          tw_re,
  output logic [DATA_W-1:0]          tw_im,
  output logic [N_LOG2-1:0]          out_k,
  output logic                       out_last
);

  localparam int SH_W = $clog2(N_LOG2);
`ifndef FFT_TWID_FULL_ROM_EN
  localparam int NQ = (2 ** N_LOG2) / 4;
`endif

  twid_state_e       state_r;
  logic [SH_W-1:0]   stage_r;
  logic              inv_r;
  logic [N_LOG2-1:0] j_r;
  logic              busy_r;

  logic              v1_r, v2_r, v3_r;
  logic [N_LOG2-1:0] k1_r, k2_r, k3_r;
  logic [N_LOG2-1:0] ra1_r, rb1_r;
  logic              inv1_r, inv2_r;
  logic              last1_r, last2_r, last3_r;
  logic [DATA_W-1:0] re3_r, im3_r;
`ifndef FFT_TWID_FULL_ROM_EN
  logic [1:0]        q1_r, q2_r;
`endif

  logic              adv1_s, adv2_s, adv3_s, issue_s;
  logic [SH_W-1:0]   sh_s;
  logic [N_LOG2-1:0] k_s, jmax_s, ra_s, rb_s;
  logic              last_j_s;
  logic [DATA_W-1:0] rom_a_s, rom_b_s;
  logic [DATA_W-1:0] re_s, im_fold_s, im_s;

  // Stall propagation: a stage may load when it is empty or it is moving on.
  always_comb begin
    adv3_s  = !v3_r || out_ready;
    adv2_s  = !v2_r || adv3_s;
    adv1_s  = !v1_r || adv2_s;
    issue_s = (state_r == RUN) && adv1_s;
  end

  // Index generation for the current j and fold address selection.
  always_comb begin
    sh_s     = SH_W'(N_LOG2 - 1) - stage_r;
    k_s      = j_r << sh_s;
    jmax_s   = (N_LOG2'(1) << stage_r) - N_LOG2'(1);
    last_j_s = (j_r == jmax_s);
`ifdef FFT_TWID_FULL_ROM_EN
    ra_s     = k_s;
    rb_s     = k_s;
`else
    ra_s     = {2'b00, k_s[N_LOG2-3:0]};
    rb_s     = N_LOG2'(NQ) - ra_s;
`endif
  end

  // Sequencer FSM: latch the request, walk j, then wait for the last hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      stage_r <= {SH_W{1'b0}};
      inv_r   <= 1'b0;
      j_r     <= {N_LOG2{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RUN;
            stage_r <= stage;
            inv_r   <= inverse;
            j_r     <= {N_LOG2{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          if (adv1_s) begin
            if (last_j_s) begin
              state_r <= DRAIN;
            end else begin
              j_r <= j_r + N_LOG2'(1);
            end
          end
        end
        DRAIN: begin
          if (v3_r && out_ready && last3_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // P1: register index, fold control and ROM addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r    <= 1'b0;
      k1_r    <= {N_LOG2{1'b0}};
      ra1_r   <= {N_LOG2{1'b0}};
      rb1_r   <= {N_LOG2{1'b0}};
      inv1_r  <= 1'b0;
      last1_r <= 1'b0;
`ifndef FFT_TWID_FULL_ROM_EN
      q1_r    <= 2'b00;
`endif
    end else if (adv1_s) begin
      v1_r    <= issue_s;
      k1_r    <= k_s;
      ra1_r   <= ra_s;
      rb1_r   <= rb_s;
      inv1_r  <= inv_r;
      last1_r <= last_j_s;
`ifndef FFT_TWID_FULL_ROM_EN
      q1_r    <= k_s[N_LOG2-1 -: 2];
`endif
    end
  end

  fft_twid_quarter_rom #(
    .N_LOG2 (N_LOG2),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .en     (adv2_s),
    .addr_a (ra1_r),
    .addr_b (rb1_r),
    .data_a (rom_a_s),
    .data_b (rom_b_s)
  );

  // P2: carry control alongside the ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r    <= 1'b0;
      k2_r    <= {N_LOG2{1'b0}};
      inv2_r  <= 1'b0;
      last2_r <= 1'b0;
`ifndef FFT_TWID_FULL_ROM_EN
      q2_r    <= 2'b00;
`endif
    end else if (adv2_s) begin
      v2_r    <= v1_r;
      k2_r    <= k1_r;
      inv2_r  <= inv1_r;
      last2_r <= last1_r;
`ifndef FFT_TWID_FULL_ROM_EN
      q2_r    <= q1_r;
`endif
    end
  end

  // Quadrant sign/swap, then optional conjugation.
  always_comb begin
    re_s      = rom_a_s;
    im_fold_s = rom_b_s;
`ifndef FFT_TWID_FULL_ROM_EN
    case (q2_r)
      2'd0:    begin re_s = rom_a_s;  im_fold_s = -rom_b_s; end
      2'd1:    begin re_s = -rom_b_s; im_fold_s = -rom_a_s; end
      2'd2:    begin re_s = -rom_a_s; im_fold_s = rom_b_s;  end
      2'd3:    begin re_s = rom_b_s;  im_fold_s = rom_a_s;  end
      default: begin re_s = {DATA_W{1'b0}}; im_fold_s = {DATA_W{1'b0}}; end
    endcase
`endif
    if (inv2_r) begin
      im_s = -im_fold_s;
    end else begin
      im_s = im_fold_s;
    end
  end

  // P3: output register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_r    <= 1'b0;
      re3_r   <= {DATA_W{1'b0}};
      im3_r   <= {DATA_W{1'b0}};
      k3_r    <= {N_LOG2{1'b0}};
      last3_r <= 1'b0;
    end else if (adv3_s) begin
      v3_r    <= v2_r;
      re3_r   <= re_s;
      im3_r   <= im_s;
      k3_r    <= k2_r;
      last3_r <= last2_r && v2_r;
    end
  end

  assign busy      = busy_r;
  assign out_valid = v3_r;
  assign tw_re     = re3_r;
  assign tw_im     = im3_r;
  assign out_k     = k3_r;
  assign out_last  = last3_r;

endmodule
